// File: rtl/dmem_mmio_console.sv
// Memory-mapped console/timer/halt peripheral decoded alongside data_memory.
// Byte TX FIFO drained over valid/ready, 64-bit cycle counter, TOHOST halt register.
module dmem_mmio_console #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted,
  output logic [31:0] exit_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;

  localparam logic [2:0] OFF_TX     = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CYC_LO = 3'd2;
  localparam logic [2:0] OFF_CYC_HI = 3'd3;
  localparam logic [2:0] OFF_TOHOST = 3'd4;

  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic        halted_q, halted_d;
  logic [31:0] exit_code_q, exit_code_d;
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] hi_snap_q, hi_snap_d;
  logic [7:0]  mem_q [FIFO_DEPTH];

  logic [2:0]  off;
  ptr_t        count;
  logic        full, empty;
  logic        push_req, push, pop;
  logic [7:0]  cnt8;
  logic [31:0] status;
  logic        unused_ok;

  // Word registers only: the two low address bits are don't-care.
  assign unused_ok = ^addr[1:0];

  assign sel   = (addr[31:5] == BASE_ADDR[31:5]);
  assign off   = addr[4:2];
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == ptr_t'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign cnt8  = 8'(count);

  assign tx_valid  = !empty;
  assign tx_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign halted    = halted_q;
  assign exit_code = exit_code_q;

  assign status = {16'h0, cnt8, 4'h0, ovf_q, halted_q, empty, full};

  // A push into a full FIFO still lands if the head leaves on the same edge.
  assign pop      = tx_valid && tx_ready;
  assign push_req = sel && we && (off == OFF_TX) && byte_en[0];
  assign push     = push_req && (!full || pop);

  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      case (off)
        OFF_STATUS: rdata = status;
        OFF_CYC_LO: rdata = cycle_q[31:0];
        OFF_CYC_HI: rdata = hi_snap_q;
        OFF_TOHOST: rdata = exit_code_q;
        default:    rdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ovf_d       = ovf_q;
    halted_d    = halted_q;
    exit_code_d = exit_code_q;
    cycle_d     = cycle_q + 64'd1;
    hi_snap_d   = hi_snap_q;

    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    if (push_req && !push) ovf_d = 1'b1;

    if (sel && we && (off == OFF_STATUS) && byte_en[0] && wdata[3])
      ovf_d = 1'b0;

    // Snapshot the high word with the LO read so a LO/HI pair is coherent.
    if (sel && re && (off == OFF_CYC_LO))
      hi_snap_d = cycle_q[63:32];

    if (sel && we && (off == OFF_TOHOST) && (byte_en == 4'b1111) && !halted_q) begin
      halted_d    = 1'b1;
      exit_code_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      halted_q    <= 1'b0;
      exit_code_q <= 32'h0;
      cycle_q     <= 64'h0;
      hi_snap_q   <= 32'h0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      halted_q    <= halted_d;
      exit_code_q <= exit_code_d;
      cycle_q     <= cycle_d;
      hi_snap_q   <= hi_snap_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata[7:0];
  end

endmodule

// File: tb/tb_dmem_mmio_console.sv
// Directed bench for dmem_mmio_console: vector table plus cycle-counter and reset sequences.
module tb_dmem_mmio_console;

  localparam logic [31:0] B = 32'h1000_0000;

  logic        clk, rst_n;
  logic [31:0] addr, wdata, rdata, exit_code;
  logic        we, re, sel, tx_valid, tx_ready, halted;
  logic [3:0]  byte_en;
  logic [7:0]  tx_data;

  dmem_mmio_console #(.BASE_ADDR(B), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .byte_en(byte_en), .rdata(rdata), .sel(sel), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .halted(halted), .exit_code(exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we, re;
    logic [3:0]  be;
    logic        txr;
    logic        exp_sel;
    logic [31:0] exp_rd;
    logic        exp_tv;
    logic [7:0]  exp_td;
    logic        exp_halt;
    logic [31:0] exp_ec;
  } vec_t;

  vec_t        tbl [64];
  int          n;
  int          total, bad;
  logic        h;
  logic [31:0] ec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r,
                     input logic [3:0] be, input logic txr, input logic esel,
                     input logic [31:0] erd, input logic etv, input logic [7:0] etd);
    tbl[n] = '{a, d, w, r, be, txr, esel, erd, etv, etd, h, ec};
    n++;
  endtask

  task automatic wr(input logic [4:0] o, input logic [31:0] d, input logic [3:0] be,
                    input logic txr, input logic etv, input logic [7:0] etd);
    add(B + 32'(o), d, 1'b1, 1'b0, be, txr, 1'b1, 32'h0, etv, etd);
  endtask

  task automatic rd(input logic [4:0] o, input logic txr, input logic [31:0] erd,
                    input logic etv, input logic [7:0] etd);
    add(B + 32'(o), 32'h0, 1'b0, 1'b1, 4'h0, txr, 1'b1, erd, etv, etd);
  endtask

  task automatic idle(input logic txr, input logic etv, input logic [7:0] etd);
    add(B, 32'h0, 1'b0, 1'b0, 4'h0, txr, 1'b1, 32'h0, etv, etd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; n = 0; h = 1'b0; ec = 32'h0;
    addr = 32'h0; wdata = 32'h0; we = 1'b0; re = 1'b0; byte_en = 4'h0; tx_ready = 1'b0;

    // Build the vector table.
    rd(5'h04, 1'b0, 32'h2, 1'b0, 8'h00);
    wr(5'h00, 32'h48, 4'h1, 1'b1, 1'b1, 8'h48);
    wr(5'h00, 32'h69, 4'h1, 1'b1, 1'b1, 8'h69);
    idle(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 9; i++) wr(5'h00, 32'(i), 4'h1, 1'b0, 1'b1, 8'h01);
    rd(5'h04, 1'b0, 32'h809, 1'b1, 8'h01);
    rd(5'h00, 1'b0, 32'h0, 1'b1, 8'h01);
    rd(5'h14, 1'b0, 32'h0, 1'b1, 8'h01);
    rd(5'h1C, 1'b0, 32'h0, 1'b1, 8'h01);
    add(B + 32'h20, 32'h55, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 32'h0, 1'b1, 8'h01);
    add(B - 32'h4, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1, 8'h01);
    wr(5'h04, 32'h8, 4'h0, 1'b0, 1'b1, 8'h01);
    rd(5'h04, 1'b0, 32'h809, 1'b1, 8'h01);
    for (int i = 2; i <= 8; i++) idle(1'b1, 1'b1, 8'(i));
    idle(1'b1, 1'b0, 8'h00);
    rd(5'h04, 1'b0, 32'hA, 1'b0, 8'h00);
    wr(5'h04, 32'h8, 4'h1, 1'b0, 1'b0, 8'h00);
    rd(5'h04, 1'b0, 32'h2, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) wr(5'h00, 32'h10 + 32'(i), 4'h1, 1'b0, 1'b1, 8'h10);
    wr(5'h00, 32'h18, 4'h1, 1'b1, 1'b1, 8'h11);
    rd(5'h04, 1'b0, 32'h801, 1'b1, 8'h11);
    for (int i = 0; i < 7; i++) idle(1'b1, 1'b1, 8'h12 + 8'(i));
    idle(1'b1, 1'b0, 8'h00);
    wr(5'h10, 32'h7, 4'h7, 1'b0, 1'b0, 8'h00);
    rd(5'h10, 1'b0, 32'h0, 1'b0, 8'h00);
    rd(5'h04, 1'b0, 32'h2, 1'b0, 8'h00);
    h = 1'b1; ec = 32'h1;
    add(B + 32'h10, 32'h1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 32'h0, 1'b0, 8'h00);
    rd(5'h10, 1'b0, 32'h1, 1'b0, 8'h00);
    wr(5'h10, 32'h5, 4'hF, 1'b0, 1'b0, 8'h00);
    rd(5'h10, 1'b0, 32'h1, 1'b0, 8'h00);
    rd(5'h04, 1'b0, 32'h6, 1'b0, 8'h00);
    wr(5'h00, 32'h77, 4'h1, 1'b0, 1'b1, 8'h77);
    idle(1'b1, 1'b0, 8'h00);

    // Reset, then idle ten edges and read the counter.
    rst_n = 1'b0;
    #1 chk("reset tx_valid", 32'(tx_valid), 32'h0);
    chk("reset halted", 32'(halted), 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    addr = B + 32'h08; re = 1'b1;
    #1 chk("cycle_lo after 10", rdata, 32'd10);
    @(negedge clk);
    addr = B + 32'h0C;
    #1 chk("cycle_hi after 10", rdata, 32'h0);
    re = 1'b0;

    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      addr = tbl[i].addr; wdata = tbl[i].wdata; we = tbl[i].we; re = tbl[i].re;
      byte_en = tbl[i].be; tx_ready = tbl[i].txr;
      #1;
      chk($sformatf("v%0d sel", i), 32'(sel), 32'(tbl[i].exp_sel));
      if (tbl[i].re || !tbl[i].exp_sel)
        chk($sformatf("v%0d rdata", i), rdata, tbl[i].exp_rd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d tx_valid", i), 32'(tx_valid), 32'(tbl[i].exp_tv));
      if (tbl[i].exp_tv) chk($sformatf("v%0d tx_data", i), 32'(tx_data), 32'(tbl[i].exp_td));
      chk($sformatf("v%0d halted", i), 32'(halted), 32'(tbl[i].exp_halt));
      chk($sformatf("v%0d exit_code", i), exit_code, tbl[i].exp_ec);
    end
    @(negedge clk);
    we = 1'b0; re = 1'b0; tx_ready = 1'b0; byte_en = 4'h0;

    // Counter at the 32-bit boundary: HI must come from the snapshot.
    @(negedge clk);
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.cycle_q;
    addr = B + 32'h08; re = 1'b1;
    #1 chk("cycle_lo at wrap", rdata, 32'hFFFF_FFFF);
    @(negedge clk);
    addr = B + 32'h0C;
    #1 chk("cycle_hi snapshot", rdata, 32'h0);
    @(negedge clk);
    addr = B + 32'h08;
    #1 chk("cycle_lo post wrap", rdata, 32'h1);
    @(negedge clk);
    addr = B + 32'h0C;
    #1 chk("cycle_hi post wrap", rdata, 32'h1);
    re = 1'b0;

    // Reset in the middle of a drain.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      addr = B; wdata = 32'hA0 + 32'(i); we = 1'b1; byte_en = 4'h1;
    end
    @(negedge clk);
    we = 1'b0; addr = B + 32'h04; re = 1'b1;
    #1 chk("mid status", rdata, 32'h404);
    chk("mid tx_data", 32'(tx_data), 32'hA0);
    tx_ready = 1'b1; re = 1'b0;
    @(posedge clk);
    #1 chk("drain tx_data", 32'(tx_data), 32'hA1);
    #2 rst_n = 1'b0;
    #1 chk("async tx_valid", 32'(tx_valid), 32'h0);
    chk("async halted", 32'(halted), 32'h0);
    chk("async exit_code", exit_code, 32'h0);
    re = 1'b1;
    #1 chk("async status", rdata, 32'h2);
    addr = B + 32'h20; we = 1'b1; wdata = 32'h55; byte_en = 4'hF;
    #1 chk("oow sel", 32'(sel), 32'h0);
    chk("oow rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b1; tx_ready = 1'b0; addr = B + 32'h04;
    #1 chk("post oow status", rdata, 32'h2);
    re = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
